// File: rtl/bj_ram_sequencer.sv
// Command sequencer that owns the blackjack game RAM port: turns bet/card/settle/round/read
// commands into ordered RAM read/write sequences with a 1-cycle registered read latency.
module bj_ram_sequencer #(
  parameter int CURRENCY_BITS = 16,
  parameter int MAX_CARDS     = 7
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [2:0]               cmd_op_i,
  input  logic                     cmd_who_i,
  input  logic [CURRENCY_BITS-1:0] cmd_data_i,
  output logic                     done_o,
  output logic [1:0]               status_o,
  output logic [CURRENCY_BITS-1:0] result_data_o,
  output logic [3:0]               ram_addr_o,
  output logic [CURRENCY_BITS-1:0] ram_wdata_o,
  output logic                     ram_we_o,
  input  logic [CURRENCY_BITS-1:0] ram_rdata_i
);
  localparam int CB = CURRENCY_BITS;

  localparam logic [2:0] OP_BET    = 3'd0;
  localparam logic [2:0] OP_ADD    = 3'd1;
  localparam logic [2:0] OP_SETTLE = 3'd2;
  localparam logic [2:0] OP_NEW    = 3'd3;
  localparam logic [2:0] OP_READ   = 3'd4;

  localparam logic [1:0] ST_OK    = 2'd0;
  localparam logic [1:0] ST_FUNDS = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;
  localparam logic [1:0] ST_BADOP = 2'd3;

  localparam logic [3:0] A_BAL   = 4'd0;
  localparam logic [3:0] A_BET   = 4'd1;
  localparam logic [3:0] A_PCNT  = 4'd2;
  localparam logic [3:0] A_DCNT  = 4'd3;
  localparam logic [3:0] A_PCARD = 4'd4;
  localparam logic [3:0] A_DCARD = 4'(4 + MAX_CARDS);

  typedef enum logic [3:0] {
    S_IDLE, S_BAL_A, S_BAL_D, S_BET_A, S_BET_D, S_WR_BAL, S_WR_BET,
    S_CNT_A, S_CNT_D, S_WR_CARD, S_WR_CNT, S_WR_PCNT, S_WR_DCNT, S_DONE
  } state_t;

  state_t        state_q;
  logic [2:0]    op_q;
  logic          who_q;
  logic [CB-1:0] data_q, bal_q, bet_q, cnt_q, result_q, wdata_q;
  logic          done_q, we_q;
  logic [1:0]    status_q;
  logic [3:0]    addr_q;

  logic [CB+1:0] credit_d, sum_d;
  logic [CB-1:0] settle_bal_d;
  logic [3:0]    cnt_addr_d, card_addr_d;
  logic          funds_bad_d, full_d;

  // Payout credit and saturating balance update; the sum carries two guard bits.
  always_comb begin
    credit_d = {(CB+2){1'b0}};
    case (data_q[1:0])
      2'd0:    credit_d = {(CB+2){1'b0}};
      2'd1:    credit_d = {2'b00, bet_q};
      2'd2:    credit_d = {1'b0, bet_q, 1'b0};
      2'd3:    credit_d = {1'b0, bet_q, 1'b0} + {3'b000, bet_q[CB-1:1]};
      default: credit_d = {(CB+2){1'b0}};
    endcase
    sum_d = {2'b00, ram_rdata_i} + credit_d;
    if (sum_d[CB+1:CB] != 2'b00) begin
      settle_bal_d = {CB{1'b1}};
    end else begin
      settle_bal_d = sum_d[CB-1:0];
    end
    cnt_addr_d  = who_q ? A_DCNT : A_PCNT;
    card_addr_d = (who_q ? A_DCARD : A_PCARD) + ram_rdata_i[3:0];
    funds_bad_d = (data_q == {CB{1'b0}}) || (data_q > bal_q);
    full_d      = (ram_rdata_i >= CB'(MAX_CARDS));
  end

  assign cmd_ready_o   = (state_q == S_IDLE) && !rst_i;
  assign done_o        = done_q;
  assign status_o      = status_q;
  assign result_data_o = result_q;
  assign ram_addr_o    = addr_q;
  assign ram_wdata_o   = wdata_q;
  assign ram_we_o      = we_q;

  // Sequencer FSM; every RAM-facing output is set on the edge entering the state that uses it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      op_q     <= 3'd0;
      who_q    <= 1'b0;
      data_q   <= {CB{1'b0}};
      bal_q    <= {CB{1'b0}};
      bet_q    <= {CB{1'b0}};
      cnt_q    <= {CB{1'b0}};
      done_q   <= 1'b0;
      status_q <= ST_OK;
      result_q <= {CB{1'b0}};
      addr_q   <= 4'd0;
      wdata_q  <= {CB{1'b0}};
      we_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      we_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            op_q   <= cmd_op_i;
            who_q  <= cmd_who_i;
            data_q <= cmd_data_i;
            case (cmd_op_i)
              OP_BET, OP_READ: begin
                addr_q  <= A_BAL;
                state_q <= S_BAL_A;
              end
              OP_ADD: begin
                addr_q  <= cmd_who_i ? A_DCNT : A_PCNT;
                state_q <= S_CNT_A;
              end
              OP_SETTLE: begin
                addr_q  <= A_BET;
                state_q <= S_BET_A;
              end
              OP_NEW: begin
                addr_q  <= A_PCNT;
                wdata_q <= {CB{1'b0}};
                we_q    <= 1'b1;
                state_q <= S_WR_PCNT;
              end
              default: begin
                state_q  <= S_DONE;
                done_q   <= 1'b1;
                status_q <= ST_BADOP;
                result_q <= {CB{1'b0}};
              end
            endcase
          end
        end
        S_BAL_A: state_q <= S_BAL_D;
        S_BAL_D: begin
          if (op_q == OP_SETTLE) begin
            bal_q   <= settle_bal_d;
            addr_q  <= A_BAL;
            wdata_q <= settle_bal_d;
            we_q    <= 1'b1;
            state_q <= S_WR_BAL;
          end else if (op_q == OP_BET) begin
            bal_q   <= ram_rdata_i;
            addr_q  <= A_BET;
            state_q <= S_BET_A;
          end else begin
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            status_q <= ST_OK;
            result_q <= ram_rdata_i;
          end
        end
        S_BET_A: state_q <= S_BET_D;
        S_BET_D: begin
          bet_q <= ram_rdata_i;
          if (op_q == OP_BET) begin
            // Funds are judged before the stale-bet check.
            if (funds_bad_d) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              status_q <= ST_FUNDS;
              result_q <= {CB{1'b0}};
            end else if (ram_rdata_i != {CB{1'b0}}) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              status_q <= ST_BADOP;
              result_q <= {CB{1'b0}};
            end else begin
              bal_q   <= bal_q - data_q;
              addr_q  <= A_BAL;
              wdata_q <= bal_q - data_q;
              we_q    <= 1'b1;
              state_q <= S_WR_BAL;
            end
          end else if (ram_rdata_i == {CB{1'b0}}) begin
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            status_q <= ST_BADOP;
            result_q <= {CB{1'b0}};
          end else begin
            addr_q  <= A_BAL;
            state_q <= S_BAL_A;
          end
        end
        S_WR_BAL: begin
          addr_q  <= A_BET;
          wdata_q <= (op_q == OP_BET) ? data_q : {CB{1'b0}};
          we_q    <= 1'b1;
          state_q <= S_WR_BET;
        end
        S_WR_BET: begin
          state_q  <= S_DONE;
          done_q   <= 1'b1;
          status_q <= ST_OK;
          result_q <= bal_q;
        end
        S_CNT_A: state_q <= S_CNT_D;
        S_CNT_D: begin
          if (full_d) begin
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            status_q <= ST_FULL;
            result_q <= {CB{1'b0}};
          end else begin
            cnt_q   <= ram_rdata_i + CB'(1);
            addr_q  <= card_addr_d;
            wdata_q <= {{(CB-4){1'b0}}, data_q[3:0]};
            we_q    <= 1'b1;
            state_q <= S_WR_CARD;
          end
        end
        S_WR_CARD: begin
          addr_q  <= cnt_addr_d;
          wdata_q <= cnt_q;
          we_q    <= 1'b1;
          state_q <= S_WR_CNT;
        end
        S_WR_CNT: begin
          state_q  <= S_DONE;
          done_q   <= 1'b1;
          status_q <= ST_OK;
          result_q <= cnt_q;
        end
        S_WR_PCNT: begin
          addr_q  <= A_DCNT;
          wdata_q <= {CB{1'b0}};
          we_q    <= 1'b1;
          state_q <= S_WR_DCNT;
        end
        S_WR_DCNT: begin
          state_q  <= S_DONE;
          done_q   <= 1'b1;
          status_q <= ST_OK;
          result_q <= {CB{1'b0}};
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bj_ram_sequencer.sv
// Bench for bj_ram_sequencer: behavioural game RAM, a command table and a done-driven scoreboard.
module tb_bj_ram_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic        cmd_who = 1'b0;
  logic [15:0] cmd_data = 16'd0;
  logic        done;
  logic [1:0]  status;
  logic [15:0] result_data;
  logic [3:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic [15:0] ram_rdata;

  logic [15:0] mem [0:15];
  logic        poke_en = 1'b0;
  logic [3:0]  poke_addr = 4'd0;
  logic [15:0] poke_data = 16'd0;

  typedef struct {
    string       tag;
    logic [1:0]  st;
    logic [15:0] res;
    int          lat;
    int          wr;
  } exp_t;

  typedef struct {
    string       tag;
    logic [2:0]  op;
    logic        who;
    logic [15:0] data;
    logic [1:0]  st;
    logic [15:0] res;
    int          lat;
    int          wr;
  } vec_t;

  exp_t sbq[$];
  exp_t mon_e;
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  int   acc_edge = 0;
  int   wr_seen = 0;

  bj_ram_sequencer #(.CURRENCY_BITS(16), .MAX_CARDS(7)) dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_who_i(cmd_who), .cmd_data_i(cmd_data), .done_o(done),
    .status_o(status), .result_data_o(result_data), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_we_o(ram_we), .ram_rdata_i(ram_rdata)
  );

  always #5 clk = ~clk;

  // Game RAM: registered read, reset loads balance 1000 and clears everything else.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= (i == 0) ? 16'd1000 : 16'd0;
      ram_rdata <= 16'd0;
    end else begin
      if (poke_en) mem[poke_addr] <= poke_data;
      else if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  // Acceptance edge and RAM writes per command, for latency and write-count checks.
  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    if (cmd_valid && cmd_ready) begin
      acc_edge <= edge_cnt + 1;
      wr_seen  <= 0;
    end else if (ram_we) begin
      wr_seen <= wr_seen + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic [1:0] st, input logic [15:0] res,
                              input int lat, input int wr);
    exp_t e;
    e.tag = tag; e.st = st; e.res = res; e.lat = lat; e.wr = wr;
    return e;
  endfunction

  // Scoreboard: every done pops the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk({mon_e.tag, "_status"}, {30'd0, status}, {30'd0, mon_e.st});
        chk({mon_e.tag, "_result"}, {16'd0, result_data}, {16'd0, mon_e.res});
        chk({mon_e.tag, "_latency"}, edge_cnt - acc_edge + 1, mon_e.lat);
        chk({mon_e.tag, "_writes"}, wr_seen, mon_e.wr);
      end
    end
  end

  task automatic wait_drain(input string tag);
    int w;
    w = 0;
    while (sbq.size() != 0 && w < 30) begin
      @(negedge clk);
      w++;
    end
    if (sbq.size() != 0) begin
      chk({tag, "_timeout"}, sbq.size(), 32'd0);
      sbq.delete();
    end
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic who, input logic [15:0] data, input exp_t e);
    int w;
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({e.tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
    if (cmd_ready) begin
      cmd_op = op; cmd_who = who; cmd_data = data; cmd_valid = 1'b1;
      sbq.push_back(e);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_data  = 16'hDEAD;
      cmd_who   = ~who;
      wait_drain(e.tag);
    end
  endtask

  task automatic poke(input logic [3:0] a, input logic [15:0] d);
    poke_addr = a; poke_data = d; poke_en = 1'b1;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl.push_back('{"rd_reset",  3'd4, 1'b0, 16'd0,    2'd0, 16'd1000, 3, 0});
    tbl.push_back('{"bet_2000",  3'd0, 1'b0, 16'd2000, 2'd1, 16'd0,    5, 0});
    tbl.push_back('{"bet_zero",  3'd0, 1'b0, 16'd0,    2'd1, 16'd0,    5, 0});
    tbl.push_back('{"bet_100",   3'd0, 1'b0, 16'd100,  2'd0, 16'd900,  7, 2});
    tbl.push_back('{"bet_again", 3'd0, 1'b0, 16'd50,   2'd3, 16'd0,    5, 0});
    tbl.push_back('{"bet_both",  3'd0, 1'b0, 16'd2000, 2'd1, 16'd0,    5, 0});
    tbl.push_back('{"rd_900",    3'd4, 1'b0, 16'd0,    2'd0, 16'd900,  3, 0});
    for (int i = 1; i <= 7; i++)
      tbl.push_back('{"add_p", 3'd1, 1'b0, 16'(i), 2'd0, 16'(i), 5, 2});
    tbl.push_back('{"add_full",  3'd1, 1'b0, 16'd8,    2'd2, 16'd0,    3, 0});
    tbl.push_back('{"add_d10",   3'd1, 1'b1, 16'd10,   2'd0, 16'd1,    5, 2});
    tbl.push_back('{"set_win",   3'd2, 1'b0, 16'd2,    2'd0, 16'd1100, 7, 2});
    tbl.push_back('{"set_nobet", 3'd2, 1'b0, 16'd3,    2'd3, 16'd0,    3, 0});
    tbl.push_back('{"bet_101",   3'd0, 1'b0, 16'd101,  2'd0, 16'd999,  7, 2});
    tbl.push_back('{"set_bj",    3'd2, 1'b0, 16'd3,    2'd0, 16'd1251, 7, 2});
    tbl.push_back('{"bet_200",   3'd0, 1'b0, 16'd200,  2'd0, 16'd1051, 7, 2});
    tbl.push_back('{"set_push",  3'd2, 1'b0, 16'd1,    2'd0, 16'd1251, 7, 2});
    tbl.push_back('{"bet_all",   3'd0, 1'b0, 16'd1251, 2'd0, 16'd0,    7, 2});
    tbl.push_back('{"set_lose",  3'd2, 1'b0, 16'd0,    2'd0, 16'd0,    7, 2});
    tbl.push_back('{"rd_zero",   3'd4, 1'b0, 16'd0,    2'd0, 16'd0,    3, 0});
    tbl.push_back('{"bet_broke", 3'd0, 1'b0, 16'd1,    2'd1, 16'd0,    5, 0});
    tbl.push_back('{"new_round", 3'd3, 1'b0, 16'd0,    2'd0, 16'd0,    3, 2});
    tbl.push_back('{"op6",       3'd6, 1'b0, 16'd0,    2'd3, 16'd0,    1, 0});
    tbl.push_back('{"op7",       3'd7, 1'b0, 16'd0,    2'd3, 16'd0,    1, 0});
    tbl.push_back('{"add_hi",    3'd1, 1'b0, 16'h0A05, 2'd0, 16'd1,    5, 2});

    repeat (3) @(negedge clk);
    chk("ready_in_rst", {31'd0, cmd_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_done",   {31'd0, done},        32'd0);
    chk("rst_status", {30'd0, status},      32'd0);
    chk("rst_result", {16'd0, result_data}, 32'd0);
    chk("rst_we",     {31'd0, ram_we},      32'd0);
    chk("rst_addr",   {28'd0, ram_addr},    32'd0);
    chk("rst_wdata",  {16'd0, ram_wdata},   32'd0);
    chk("rst_ready",  {31'd0, cmd_ready},   32'd1);

    foreach (tbl[i])
      run_cmd(tbl[i].op, tbl[i].who, tbl[i].data,
              mk(tbl[i].tag, tbl[i].st, tbl[i].res, tbl[i].lat, tbl[i].wr));

    chk("mem_bal",   {16'd0, mem[0]}, 32'd0);
    chk("mem_bet",   {16'd0, mem[1]}, 32'd0);
    chk("mem_pcnt",  {16'd0, mem[2]}, 32'd1);
    chk("mem_dcnt",  {16'd0, mem[3]}, 32'd0);
    chk("mem_card0", {16'd0, mem[4]}, 32'd5);
    for (int i = 5; i <= 10; i++) chk("mem_pcard", {16'd0, mem[i]}, 32'(i - 3));
    chk("mem_dcard", {16'd0, mem[11]}, 32'd10);

    // Saturation and exact-max boundaries of the settle arithmetic.
    poke(4'd0, 16'd65500); poke(4'd1, 16'd100);
    run_cmd(3'd2, 1'b0, 16'd2, mk("sat_win", 2'd0, 16'd65535, 7, 2));
    chk("sat_bet_cleared", {16'd0, mem[1]}, 32'd0);
    poke(4'd0, 16'd65335); poke(4'd1, 16'd100);
    run_cmd(3'd2, 1'b0, 16'd2, mk("exact_max", 2'd0, 16'd65535, 7, 2));
    poke(4'd0, 16'd65535); poke(4'd1, 16'd65535);
    run_cmd(3'd2, 1'b0, 16'd3, mk("sat_bj_max", 2'd0, 16'd65535, 7, 2));
    chk("sat_mem_bal", {16'd0, mem[0]}, 32'd65535);

    // Command held during done is taken one cycle later.
    cmd_op = 3'd4; cmd_valid = 1'b1;
    sbq.push_back(mk("b2b_first", 2'd0, 16'd65535, 3, 0));
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int w = 0; w < 20 && !done; w++) @(negedge clk);
    chk("b2b_done_seen", {31'd0, done}, 32'd1);
    chk("b2b_ready_in_done", {31'd0, cmd_ready}, 32'd0);
    cmd_valid = 1'b1;
    sbq.push_back(mk("b2b_second", 2'd0, 16'd65535, 3, 0));
    @(negedge clk);
    chk("b2b_ready_after", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("b2b_busy", {31'd0, cmd_ready}, 32'd0);
    wait_drain("b2b");

    // Reset while SETTLE is writing the balance abandons the command.
    poke(4'd0, 16'd500); poke(4'd1, 16'd100);
    cmd_op = 3'd2; cmd_data = 16'd2; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_we",    {31'd0, ram_we},    32'd1);
    chk("mid_addr",  {28'd0, ram_addr},  32'd0);
    chk("mid_wdata", {16'd0, ram_wdata}, 32'd700);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_done",  {31'd0, done},      32'd0);
    chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_ready_after", {31'd0, cmd_ready},   32'd1);
    chk("mid_status",      {30'd0, status},      32'd0);
    chk("mid_result",      {16'd0, result_data}, 32'd0);
    chk("mid_done",        {31'd0, done},        32'd0);
    @(negedge clk);
    run_cmd(3'd4, 1'b0, 16'd0, mk("rd_after_rst", 2'd0, 16'd1000, 3, 0));
    chk("mem_bal_after_rst", {16'd0, mem[0]}, 32'd1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bj_ram_sequencer.md
Name: bj_ram_sequencer

Overview:
- Command-driven controller that owns the single port of blackjack_game_ram (addr/write_data/write_en/read_data).
- Turns game-level commands (place bet, add card, settle, new round, read balance) into ordered RAM read/write sequences.
- Enforces the RAM's 1-cycle registered read latency, range checks and payout arithmetic.
- Sits between the game FSM and the RAM. It is the only writer to the RAM.

Parameters:
- CURRENCY_BITS, 16, width of balance/bet/RAM data words.
- MAX_CARDS, 7, card slots per hand; player cards at 4..3+MAX_CARDS, dealer cards at 4+MAX_CARDS..3+2*MAX_CARDS.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset (shared with RAM)
- cmd_valid  in  1  command request
- cmd_ready  out  1  controller idle; command accepted when cmd_valid&&cmd_ready at posedge
- cmd_op  in  3  0 PLACE_BET, 1 ADD_CARD, 2 SETTLE, 3 NEW_ROUND, 4 READ_BALANCE, 5-7 illegal
- cmd_who  in  1  ADD_CARD hand select: 0 player, 1 dealer
- cmd_data  in  CURRENCY_BITS  bet amount / card value in [3:0] / settle outcome in [1:0] (0 lose, 1 push, 2 win, 3 blackjack)
- done  out  1  one-cycle completion pulse
- status  out  2  0 OK, 1 ERR_FUNDS, 2 ERR_FULL, 3 ERR_BADOP; valid with done, held until next done
- result_data  out  CURRENCY_BITS  new balance (BET/SETTLE/READ), new count (ADD_CARD), 0 otherwise; held like status
- ram_addr  out  4  to RAM addr
- ram_wdata  out  CURRENCY_BITS  to RAM write_data
- ram_we  out  1  to RAM write_en
- ram_rdata  in  CURRENCY_BITS  from RAM read_data

Behaviour:
- RAM map: 0 balance, 1 current bet, 2 player count, 3 dealer count, then card arrays as above.
- Read protocol: addr driven in state X_A; ram_rdata sampled in following state X_D. No other timing is assumed.
- Outputs are registered. cmd_ready = (state==IDLE) && !rst.
- Reset: state IDLE; done, ram_we, status, result_data, ram_addr, ram_wdata all 0. Reset mid-command abandons the command with no done. The RAM reinitialises on the same rst (balance 1000).
- Command fields are latched on acceptance. Inputs are ignored while busy.
- At most one RAM write per cycle. ram_we is high only in write states.
- Latency: N = cycles from acceptance edge to the done cycle.
- PLACE_BET: BAL_A, BAL_D, BET_A, BET_D, WR_BAL(balance−amt), WR_BET(amt), DONE; N=7.
  - amt==0 or amt>balance: ERR_FUNDS, no writes, N=5.
  - Stored bet !=0: ERR_BADOP, no writes, N=5. Funds are checked first.
- ADD_CARD: CNT_A, CNT_D, WR_CARD(addr=base+count, data=cmd_data[3:0] zero-extended), WR_CNT(count+1), DONE; N=5.
  - count>=MAX_CARDS: ERR_FULL, no writes, N=3.
- SETTLE: BET_A, BET_D, BAL_A, BAL_D, WR_BAL, WR_BET(0), DONE; N=7.
  - Credit: lose 0, push bet, win 2·bet, blackjack 2·bet+(bet>>1) (floor).
  - Sum computed in CURRENCY_BITS+2 bits, saturated to all-ones.
  - Stored bet==0: ERR_BADOP, no writes, N=3.
- NEW_ROUND: WR player count=0, WR dealer count=0, DONE; N=3. Bet and card slots are untouched.
- READ_BALANCE: BAL_A, BAL_D, DONE; N=3.
- Illegal op: DONE with ERR_BADOP; N=1.
- Back-to-back: cmd_ready rises the cycle after done. A command asserted during done is accepted one cycle later.

Test Plan:
- After reset, READ_BALANCE → done at N=3, status 0, result 1000, ram_we never high.
- PLACE_BET 100 → writes addr0=900 then addr1=100, result 900. A second PLACE_BET 50 → ERR_BADOP, RAM unchanged.
- PLACE_BET 2000 with balance 1000 → ERR_FUNDS at N=5, no write.
- ADD_CARD player values 1..7 → counts 1..7, cards at addr 4..10. An 8th → ERR_FULL, N=3. ADD_CARD dealer 10 → addr 11 = 10, addr3 = 1.
- Bet 101, SETTLE blackjack → balance 899+202+50=1151, bet 0. Then SETTLE again → ERR_BADOP. Balance 65500 plus win of 100 saturates to 65535.
- rst asserted in WR_BAL of SETTLE → no done, cmd_ready high the cycle after rst drops, READ_BALANCE returns 1000. cmd_op=6 → ERR_BADOP at N=1.
